// File: rtl/overture_exec_ctrl_if.sv
// Fetch, I/O and ALU signal bundle between the OVERTURE execution controller and its surroundings.
// The controller connects through master; the environment (memory, I/O, ALU) through slave.
interface overture_exec_ctrl_if;
    logic [7:0] instr;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] pc;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] alu_instr;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [7:0] alu_result;

    modport master (
        input  instr, instr_valid, in_data, in_valid, out_ready, alu_result,
        output instr_ready, pc, in_ready, out_data, out_valid, alu_instr, alu_a, alu_b
    );

    modport slave (
        output instr, instr_valid, in_data, in_valid, out_ready, alu_result,
        input  instr_ready, pc, in_ready, out_data, out_valid, alu_instr, alu_a, alu_b
    );
endinterface

// File: rtl/overture_exec_ctrl.sv
// OVERTURE 8-bit CPU execution controller: fetch/decode, register file, pc,
// ALU issue/capture, conditional jumps and blocking input/output handshakes.
module overture_exec_ctrl #(
    parameter int         UUID     = 0,
    parameter string      NAME     = "",
    parameter logic [7:0] PC_RESET = 8'd0
) (
    input  logic                 clk,
    input  logic                 rst,
    overture_exec_ctrl_if.master bus
);

    localparam int unsigned DW     = 8;
    localparam int unsigned NREG   = 6;
    localparam logic [2:0]  IO_SEL = 3'd6;

    typedef enum logic [1:0] {
        FETCH    = 2'd0,
        CALC     = 2'd1,
        IN_WAIT  = 2'd2,
        OUT_WAIT = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [DW-1:0]   regs_q [NREG];
    logic [DW-1:0]   pc_q, pc_d;
    logic [DW-1:0]   out_data_q, out_data_d;
    logic [DW-1:0]   alu_instr_q, alu_instr_d;
    logic [2:0]      dst_q, dst_d;
    logic            instr_ready_q, in_ready_q, out_valid_q;

    logic            wr_en;
    logic [2:0]      wr_idx;
    logic [DW-1:0]   wr_val;

    logic [DW-1:0]   pc_inc;
    logic [2:0]      instr_src, instr_dst;
    logic [DW-1:0]   src_value;
    logic            r3_zero, r3_neg, cond_taken;

    assign pc_inc    = pc_q + DW'(1);
    assign instr_src = bus.instr[5:3];
    assign instr_dst = bus.instr[2:0];

    // Source operand of a COPY; selector 7 reads as zero
    always_comb begin
        src_value = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            if (instr_src == 3'(i)) src_value = regs_q[i];
        end
    end

    // Condition evaluation on REG3 as a signed byte
    always_comb begin
        r3_zero = (regs_q[3] == '0);
        r3_neg  = regs_q[3][DW-1];
        unique case (bus.instr[2:0])
            3'd0:    cond_taken = 1'b0;
            3'd1:    cond_taken = r3_zero;
            3'd2:    cond_taken = r3_neg;
            3'd3:    cond_taken = r3_neg | r3_zero;
            3'd4:    cond_taken = 1'b1;
            3'd5:    cond_taken = ~r3_zero;
            3'd6:    cond_taken = ~r3_neg;
            default: cond_taken = ~r3_neg & ~r3_zero;
        endcase
    end

    // Next-state and datapath decode
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        out_data_d  = out_data_q;
        alu_instr_d = alu_instr_q;
        dst_d       = dst_q;
        wr_en       = 1'b0;
        wr_idx      = '0;
        wr_val      = '0;

        unique case (state_q)
            FETCH: begin
                if (bus.instr_valid) begin
                    unique case (bus.instr[7:6])
                        2'b00: begin
                            wr_en  = 1'b1;
                            wr_idx = 3'd0;
                            wr_val = {2'b00, bus.instr[5:0]};
                            pc_d   = pc_inc;
                        end
                        2'b01: begin
                            alu_instr_d = {5'b0, bus.instr[2:0]};
                            state_d     = CALC;
                        end
                        2'b10: begin
                            if (instr_src == IO_SEL) begin
                                dst_d   = instr_dst;
                                state_d = IN_WAIT;
                            end else if (instr_dst == IO_SEL) begin
                                out_data_d = src_value;
                                state_d    = OUT_WAIT;
                            end else begin
                                wr_en  = 1'b1;
                                wr_idx = instr_dst;
                                wr_val = src_value;
                                pc_d   = pc_inc;
                            end
                        end
                        default: begin
                            pc_d = cond_taken ? regs_q[0] : pc_inc;
                        end
                    endcase
                end
            end
            CALC: begin
                wr_en       = 1'b1;
                wr_idx      = 3'd3;
                wr_val      = bus.alu_result;
                alu_instr_d = '0;
                pc_d        = pc_inc;
                state_d     = FETCH;
            end
            IN_WAIT: begin
                if (bus.in_valid) begin
                    if (dst_q == IO_SEL) begin
                        out_data_d = bus.in_data;
                        state_d    = OUT_WAIT;
                    end else begin
                        wr_en   = 1'b1;
                        wr_idx  = dst_q;
                        wr_val  = bus.in_data;
                        pc_d    = pc_inc;
                        state_d = FETCH;
                    end
                end
            end
            default: begin
                if (bus.out_ready) begin
                    pc_d    = pc_inc;
                    state_d = FETCH;
                end
            end
        endcase
    end

    // State, registers and handshake flags; flags mirror the decoded next state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= FETCH;
            pc_q          <= PC_RESET;
            out_data_q    <= '0;
            alu_instr_q   <= '0;
            dst_q         <= '0;
            instr_ready_q <= 1'b1;
            in_ready_q    <= 1'b0;
            out_valid_q   <= 1'b0;
            for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            out_data_q    <= out_data_d;
            alu_instr_q   <= alu_instr_d;
            dst_q         <= dst_d;
            instr_ready_q <= (state_d == FETCH);
            in_ready_q    <= (state_d == IN_WAIT);
            out_valid_q   <= (state_d == OUT_WAIT);
            // Selectors 6 and 7 never match, so such writes are dropped
            for (int i = 0; i < int'(NREG); i++) begin
                if (wr_en && (wr_idx == 3'(i))) regs_q[i] <= wr_val;
            end
        end
    end

    assign bus.instr_ready = instr_ready_q;
    assign bus.pc          = pc_q;
    assign bus.in_ready    = in_ready_q;
    assign bus.out_data    = out_data_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.alu_instr   = alu_instr_q;
    assign bus.alu_a       = regs_q[1];
    assign bus.alu_b       = regs_q[2];

endmodule
